sramlike_axi_bridge: RTL and testbench
======================================

# sramlike_axi_bridge
Responder side of the SRAM-like data-port handshake issued by the write-back D-cache (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out), converting each accepted request into a single-beat AXI read (AR/R) or write (AW/W/B) transaction. It sits between the D-cache miss/writeback path and the AXI crossbar, with one transaction in flight by default.
## Interface
- (no parameters; all widths fixed at 32-bit address/data, single beat)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  1  SRAM-like request, held by the cache until addr_ok
- wr  in  1  1 = write, 0 = read
- size  in  2  0 = byte, 1 = half, 2 = word
- addr  in  32  byte address, passed unmodified to AXI
- wdata  in  32  write data, lane-aligned as the core supplies it
- rdata  out  32  read data, valid only in the data_ok cycle
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  transaction complete, one-cycle pulse
- araddr / arsize / arvalid  out  32/3/1  AXI read address channel
- arready  in  1  AXI read address ready
- axi_rdata  in  32  AXI read data
- rvalid  in  1  AXI read data valid
- rready  out  1  AXI read data ready
- awaddr / awsize / awvalid  out  32/3/1  AXI write address channel
- awready  in  1  AXI write address ready
- axi_wdata / wstrb / wvalid  out  32/4/1  AXI write data channel (wlast tied 1 at top)
- wready  in  1  AXI write data ready
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response ready
## Operation
- FSM states: IDLE, AR, R, AWW, B.
- IDLE: addr_ok = req (combinational); on req latch addr, size, wr, wdata; wr=0 -> AR, wr=1 -> AWW.
- AR: arvalid=1 until arready -> R. R: rready=1; rvalid -> data_ok=1, rdata=axi_rdata, -> IDLE.
- AWW: awvalid and wvalid raised together; each drops independently on its own handshake (aw_done/w_done flags); both done -> B. Simultaneous AW and W handshakes in one cycle go straight to B.
- B: bready=1; bvalid -> data_ok=1, -> IDLE.
- arsize = awsize = {1'b0,size}. wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> addr[1] ? 4'b1100 : 4'b0011; size 2 -> 4'b1111; size 3 -> 4'b1111 (never issued by core).
- rresp/bresp are ignored; errors complete normally.
## Timing
- Reset values: state IDLE, all valid/ready outputs 0, addr_ok 0, data_ok 0, latched registers 0; rdata tracks axi_rdata combinationally.
- Read with zero-wait slave: addr_ok cycle 0, arvalid cycle 1, data_ok no earlier than cycle 2.
- addr_ok is never asserted outside IDLE; a new request is accepted in the cycle after data_ok at the earliest.
- rst mid-transaction drops all valids next edge and returns to IDLE; no data_ok is produced.
## Configuration
- BRIDGE_POSTED_WRITE_EN defined: write data_ok fires in the cycle the last of AW/W completes; FSM returns to IDLE with b_pending=1 and bready=b_pending until bvalid. In IDLE with b_pending, reads are accepted unless addr[31:2] equals the pending write's addr[31:2] (addr_ok held low until B); writes wait for B.
- Undefined: data_ok for writes waits for B; b_pending logic absent.
## Structure
- bridge_pkg: FSM state enum, AXI size encodings, wstrb_from_size function.
- One sub-module natural: axi_wstrb_gen (size, addr[1:0] -> wstrb), shared later with the I-side bridge.
## Test plan
- Read word addr 0x1000, slave returns 0xCAFEBABE after 3 cycles -> one data_ok, rdata=0xCAFEBABE, araddr=0x1000, arsize=3'b010.
- Byte write addr 0x2003, wdata 0xAB000000 -> wstrb=4'b1000, awsize=0, data_ok only after bvalid.
- awready 4 cycles after wready -> wvalid drops after its handshake, awvalid held, exactly one data_ok after B.
- Writeback then refill: write 0x3000 immediately followed by read 0x7000 -> read addr_ok the cycle after write data_ok, no overlap of channels.
- rst asserted while in R with rvalid low -> next cycle rready=0, state IDLE, no data_ok; fresh read completes normally.
- BRIDGE_POSTED_WRITE_EN: write 0x4000, bvalid delayed 10 cycles; read 0x4000 waits for B, read 0x5000 accepted before B.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI bridges: FSM state encoding,
// AXI transfer-size codes and the byte-strobe rule for single-beat writes.
package bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AWW,
    S_B
  } state_t;

  localparam logic [2:0] AXI_SIZE_BYTE = 3'b000;
  localparam logic [2:0] AXI_SIZE_HALF = 3'b001;
  localparam logic [2:0] AXI_SIZE_WORD = 3'b010;

  // Byte lanes touched by a core access of the given size at addr[1:0].
  function automatic logic [3:0] wstrb_from_size(input logic [1:0] size,
                                                 input logic [1:0] addr_lo);
    case ({1'b0, size})
      AXI_SIZE_BYTE: return 4'b0001 << addr_lo;
      AXI_SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      AXI_SIZE_WORD: return 4'b1111;
      default:       return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/axi_wstrb_gen.sv
// Write-strobe generator: maps core access size and low address bits onto
// AXI byte lanes. Purely combinational so it can be shared by both bridges.
module axi_wstrb_gen
  import bridge_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  assign wstrb = wstrb_from_size(size, addr_lo);

endmodule

// File: rtl/sramlike_axi_bridge.sv
// SRAM-like responder for the D-cache data port, turning each accepted request
// into one single-beat AXI read (AR/R) or write (AW/W/B).
// Optional feature: define BRIDGE_POSTED_WRITE_EN to complete writes to the
// cache as soon as AW and W are both accepted, with B collected in the
// background.
module sramlike_axi_bridge
  import bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] axi_rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] axi_wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, state_n;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic        aw_done, w_done;
  logic        accept_ok;
  logic        bready_fsm;

`ifdef BRIDGE_POSTED_WRITE_EN
  logic        b_pending;
  logic [29:0] b_word;

  // With a write response outstanding only reads to a different word may pass.
  assign accept_ok = !b_pending || (!wr && (addr[31:2] != b_word));
  assign bready    = b_pending;
`else
  assign accept_ok = 1'b1;
  assign bready    = bready_fsm;
`endif

  // Request direction is carried by the AR/AWW state, so only the address,
  // size and data need holding for the AXI side.
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = {1'b0, size_q};
  assign awsize    = {1'b0, size_q};
  assign axi_wdata = wdata_q;
  assign rdata     = axi_rdata;

  axi_wstrb_gen u_wstrb (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  // Next-state and handshake outputs for the single outstanding transaction.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    state_n    = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    bready_fsm = 1'b0;
    case (state)
      S_IDLE: begin
        if (req && accept_ok) begin
          addr_ok = 1'b1;
          state_n = wr ? S_AWW : S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_n = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid) begin
          data_ok = 1'b1;
          state_n = S_IDLE;
        end
      end
      S_AWW: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        if ((aw_done || awready) && (w_done || wready)) begin
`ifdef BRIDGE_POSTED_WRITE_EN
          data_ok = 1'b1;
          state_n = S_IDLE;
`else
          state_n = S_B;
`endif
        end
      end
      S_B: begin
        bready_fsm = 1'b1;
        if (bvalid) begin
          data_ok = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // A cycle with reset asserted must never accept or complete anything.
    if (rst) begin
      addr_ok = 1'b0;
      data_ok = 1'b0;
    end
  end

  // State register, request capture and per-channel completion flags.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state   <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_n;
      if (addr_ok) begin
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_AWW) begin
        aw_done <= aw_done | (awvalid & awready);
        w_done  <= w_done | (wvalid & wready);
      end
    end
  end

`ifdef BRIDGE_POSTED_WRITE_EN
  // Track the write response still owed after a posted write completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_pending <= 1'b0;
      b_word    <= '0;
    end else if (state == S_AWW && state_n == S_IDLE) begin
      b_pending <= 1'b1;
      b_word    <= addr_q[31:2];
    end else if (b_pending && bvalid) begin
      b_pending <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sramlike_axi_bridge.sv
// Self-checking bench for sramlike_axi_bridge: a cycle-stepped AXI slave and
// cache master with a transaction-level reference of the expected handshakes.
module tb_sramlike_axi_bridge;

`ifdef BRIDGE_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  always #5 clk = ~clk;

  sramlike_axi_bridge dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .axi_wdata(axi_wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int passed = 0, total = 0;

  // Master side: requests waiting to be accepted, and the one in flight.
  txn_t req_q[$];
  txn_t cur;
  bit   busy, ar_done, aw_done_m, w_done_m, b_sched;

  // Slave side timing and pending responses.
  int          ar_dly, aw_dly, w_dly, r_dly, b_dly, ar_cnt, aw_cnt, w_cnt;
  bit          rnd_dly, use_fixed;
  logic [31:0] fixed_rdata, r_val, b_addr_m;
  bit          r_pend, b_pend, b_out;
  int          r_wait, b_wait;

  int cyc, n_dok;
  int aok_log[$], dok_log[$], b_log[$];

  function automatic logic [3:0] ref_strb(input txn_t t);
    logic [3:0] s;
    s = 4'b0000;
    case (t.size)
      2'd0:    s[t.addr[1:0]] = 1'b1;
      2'd1:    s = t.addr[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  task automatic clear_model();
    busy = 0; ar_done = 0; aw_done_m = 0; w_done_m = 0; b_sched = 0;
    r_pend = 0; b_pend = 0; b_out = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
  endtask

  task automatic set_dly(input int a, input int r, input int aw, input int w, input int b);
    ar_dly = a; r_dly = r; aw_dly = aw; w_dly = w; b_dly = b;
  endtask

  // One clock: drive master and slave, compare all handshakes, advance model.
  task automatic step();
    logic [6:0] obs, exp_v;
    bit e_ar, e_r, e_aw, e_w, e_b, e_dok, e_aok, hs_aw, hs_w;
    @(negedge clk);
    cyc++;
    if (req_q.size() > 0) begin
      req = 1'b1; wr = req_q[0].wr; size = req_q[0].size;
      addr = req_q[0].addr; wdata = req_q[0].wdata;
    end else begin
      req = 1'b0; wr = 1'b0; size = 2'd0; addr = $urandom; wdata = $urandom;
    end
    arready   = (ar_cnt >= ar_dly);
    awready   = (aw_cnt >= aw_dly);
    wready    = (w_cnt >= w_dly);
    rvalid    = r_pend && (r_wait == 0);
    axi_rdata = rvalid ? r_val : $urandom;
    bvalid    = b_pend && (b_wait == 0);
    #1;
    e_ar  = busy && !cur.wr && !ar_done;
    e_r   = busy && !cur.wr && ar_done;
    e_aw  = busy && cur.wr && !aw_done_m;
    e_w   = busy && cur.wr && !w_done_m;
    e_b   = POSTED ? b_out : (busy && cur.wr && aw_done_m && w_done_m);
    hs_aw = e_aw && awready;
    hs_w  = e_w && wready;
    if (!busy)        e_dok = 1'b0;
    else if (!cur.wr) e_dok = ar_done && rvalid;
    else if (POSTED)  e_dok = (aw_done_m || hs_aw) && (w_done_m || hs_w);
    else              e_dok = aw_done_m && w_done_m && bvalid;
    e_aok = req && !busy &&
            (!POSTED || !b_out || (!wr && (addr[31:2] != b_addr_m[31:2])));
    obs   = {addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready};
    exp_v = {e_aok, e_dok, e_ar, e_r, e_aw, e_w, e_b};
    total++;
    if (obs !== exp_v)
      $display("FAIL handshake cyc %0d: aok/dok/ar/r/aw/w/b got %b want %b", cyc, obs, exp_v);
    else passed++;
    if (e_ar && arready) begin
      total++;
      if ({araddr, arsize} !== {cur.addr, 1'b0, cur.size})
        $display("FAIL ar_channel: got %h/%0d want %h/%0d", araddr, arsize, cur.addr, cur.size);
      else passed++;
    end
    if (hs_aw) begin
      total++;
      if ({awaddr, awsize} !== {cur.addr, 1'b0, cur.size})
        $display("FAIL aw_channel: got %h/%0d want %h/%0d", awaddr, awsize, cur.addr, cur.size);
      else passed++;
    end
    if (hs_w) begin
      total++;
      if ({axi_wdata, wstrb} !== {cur.wdata, ref_strb(cur)})
        $display("FAIL w_channel: got %h/%b want %h/%b", axi_wdata, wstrb, cur.wdata, ref_strb(cur));
      else passed++;
    end
    if (e_dok && !cur.wr) begin
      total++;
      if (rdata !== r_val) $display("FAIL rdata: got %h want %h", rdata, r_val);
      else passed++;
    end
    // Advance the reference.
    if (r_pend && r_wait > 0) r_wait--;
    if (b_pend && b_wait > 0) b_wait--;
    if (bvalid && e_b) begin b_pend = 0; b_out = 0; b_log.push_back(cyc); end
    if (e_ar) begin
      if (arready) begin
        ar_done = 1; ar_cnt = 0; r_pend = 1; r_wait = r_dly;
        r_val = use_fixed ? fixed_rdata : $urandom;
      end else ar_cnt++;
    end
    if (e_aw) begin if (awready) begin aw_done_m = 1; aw_cnt = 0; end else aw_cnt++; end
    if (e_w)  begin if (wready)  begin w_done_m = 1;  w_cnt = 0;  end else w_cnt++;  end
    if (busy && cur.wr && aw_done_m && w_done_m && !b_sched) begin
      b_sched = 1; b_pend = 1; b_wait = b_dly;
      if (POSTED) begin b_out = 1; b_addr_m = cur.addr; end
    end
    if (e_dok) begin
      n_dok++; dok_log.push_back(cyc); busy = 0;
      if (!cur.wr) r_pend = 0;
    end
    if (e_aok) begin
      cur = req_q.pop_front();
      busy = 1; ar_done = 0; aw_done_m = 0; w_done_m = 0; b_sched = 0;
      aok_log.push_back(cyc);
      if (rnd_dly) set_dly($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 4),
                           $urandom_range(0, 4), $urandom_range(0, 5));
    end
  endtask

  // Step until every queued request and response has drained, within a bound.
  task automatic run(input int max_cyc, input string name);
    int n = 0;
    while ((req_q.size() > 0 || busy || b_pend || b_out) && n < max_cyc) begin
      step();
      n++;
    end
    total++;
    if (n >= max_cyc) $display("FAIL %s timeout: got %0d cycles want < %0d", name, n, max_cyc);
    else passed++;
  endtask

  task automatic start_test();
    aok_log.delete(); dok_log.delete(); b_log.delete();
  endtask

  task automatic push(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.wr = w; t.size = s; t.addr = a; t.wdata = d;
    req_q.push_back(t);
  endtask

  task automatic test_reset();
    logic [113:0] got, want;
    rst = 1'b1; req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h1234_5678; wdata = $urandom;
    repeat (3) @(negedge clk);
    axi_rdata = 32'h5A5A_1234;
    #1;
    got  = {addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready,
            araddr, awaddr, axi_wdata, arsize, awsize, wstrb};
    want = {7'b0, 96'h0, 3'b0, 3'b0, 4'b0001};
    total++;
    if (got !== want) $display("FAIL reset_outputs: got %h want %h", got, want);
    else passed++;
    total++;
    if (rdata !== 32'h5A5A_1234) $display("FAIL rdata_passthru: got %h want 5a5a1234", rdata);
    else passed++;
    rst = 1'b0; req = 1'b0;
    clear_model();
  endtask

  task automatic test_read();
    int d0 = n_dok;
    start_test();
    set_dly(0, 2, 0, 0, 0);
    use_fixed = 1; fixed_rdata = 32'hCAFE_BABE;
    push(1'b0, 2'd2, 32'h0000_1000, 32'h0);
    run(50, "read");
    use_fixed = 0;
    total++;
    if (n_dok - d0 !== 1) $display("FAIL read_data_ok_count: got %0d want 1", n_dok - d0);
    else passed++;
  endtask

  task automatic test_byte_write();
    int d0 = n_dok;
    start_test();
    set_dly(0, 0, 0, 0, 3);
    push(1'b1, 2'd0, 32'h0000_2003, 32'hAB00_0000);
    run(50, "byte_write");
    total++;
    if (n_dok - d0 !== 1) $display("FAIL byte_write_data_ok_count: got %0d want 1", n_dok - d0);
    else passed++;
  endtask

  task automatic test_aw_late();
    int d0 = n_dok;
    start_test();
    set_dly(0, 0, 4, 0, 1);
    push(1'b1, 2'd2, 32'h0000_2100, 32'h1122_3344);
    run(50, "aw_late");
    total++;
    if (n_dok - d0 !== 1) $display("FAIL aw_late_data_ok_count: got %0d want 1", n_dok - d0);
    else passed++;
  endtask

  task automatic test_back_to_back();
    start_test();
    set_dly(0, 0, 0, 0, 0);
    push(1'b1, 2'd2, 32'h0000_3000, 32'hDEAD_BEEF);
    push(1'b0, 2'd2, 32'h0000_7000, 32'h0);
    run(80, "back_to_back");
    total++;
    if (aok_log.size() != 2 || dok_log.size() != 2 || aok_log[1] != dok_log[0] + 1)
      $display("FAIL b2b_accept_cycle: got %0d want %0d",
               aok_log.size() > 1 ? aok_log[1] : -1, dok_log.size() > 0 ? dok_log[0] + 1 : -1);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int n = 0, d0;
    start_test();
    set_dly(0, 30, 0, 0, 0);
    push(1'b0, 2'd2, 32'h0000_6000, 32'h0);
    while (!(busy && ar_done) && n < 20) begin step(); n++; end
    step();
    d0 = n_dok;
    @(negedge clk);
    rst = 1'b1; req = 1'b0; rvalid = 1'b0;
    #1;
    total++;
    if (data_ok !== 1'b0) $display("FAIL rst_no_data_ok: got %b want 0", data_ok);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({arvalid, rready, awvalid, wvalid, bready, data_ok} !== 6'b0)
      $display("FAIL rst_mid_outputs: got %b want 000000",
               {arvalid, rready, awvalid, wvalid, bready, data_ok});
    else passed++;
    clear_model();
    set_dly(1, 1, 0, 0, 0);
    push(1'b0, 2'd2, 32'h0000_6004, 32'h0);
    run(50, "read_after_rst");
    total++;
    if (n_dok - d0 !== 1) $display("FAIL read_after_rst_count: got %0d want 1", n_dok - d0);
    else passed++;
  endtask

  task automatic test_random();
    int d0 = n_dok;
    logic [31:0] a;
    logic [1:0]  s;
    start_test();
    rnd_dly = 1;
    set_dly(1, 1, 1, 1, 1);
    for (int i = 0; i < 40; i++) begin
      s = 2'($urandom_range(0, 2));
      a = $urandom;
      if (s == 2'd1) a[0] = 1'b0;
      if (s == 2'd2) a[1:0] = 2'b00;
      push(1'($urandom_range(0, 1)), s, a, $urandom);
    end
    run(3000, "random");
    rnd_dly = 0;
    total++;
    if (n_dok - d0 !== 40) $display("FAIL random_data_ok_count: got %0d want 40", n_dok - d0);
    else passed++;
  endtask

`ifdef BRIDGE_POSTED_WRITE_EN
  task automatic test_posted();
    start_test();
    set_dly(0, 0, 0, 0, 10);
    push(1'b1, 2'd2, 32'h0000_4000, 32'h0BAD_F00D);
    push(1'b0, 2'd2, 32'h0000_5000, 32'h0);
    run(80, "posted_other");
    total++;
    if (aok_log.size() != 2 || b_log.size() != 1 || !(aok_log[1] < b_log[0]))
      $display("FAIL posted_read_bypass: got accept %0d want before B %0d",
               aok_log.size() > 1 ? aok_log[1] : -1, b_log.size() > 0 ? b_log[0] : -1);
    else passed++;
    start_test();
    push(1'b1, 2'd2, 32'h0000_4000, 32'h1357_9BDF);
    push(1'b0, 2'd2, 32'h0000_4000, 32'h0);
    run(80, "posted_same");
    total++;
    if (aok_log.size() != 2 || b_log.size() != 1 || !(aok_log[1] > b_log[0]))
      $display("FAIL posted_read_blocked: got accept %0d want after B %0d",
               aok_log.size() > 1 ? aok_log[1] : -1, b_log.size() > 0 ? b_log[0] : -1);
    else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wdata = '0;
    arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    axi_rdata = '0;
    rnd_dly = 0; use_fixed = 0; fixed_rdata = '0; r_val = '0; b_addr_m = '0;
    r_wait = 0; b_wait = 0; cyc = 0; n_dok = 0; cur = '0;
    set_dly(0, 0, 0, 0, 0);
    clear_model();
    test_reset();
    test_read();
    test_byte_write();
    test_aw_late();
    test_back_to_back();
    test_reset_mid();
`ifdef BRIDGE_POSTED_WRITE_EN
    test_posted();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
